// File: rtl/alu_arb.sv
// Two-port round-robin arbiter in front of a single 32-bit ALU.
// One operation in flight at a time: IDLE (accept) -> EXEC (evaluate) -> RESP (hold result).
module alu_arb #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_over,
    output logic             rsp_err
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpOr  = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0011;
    localparam logic [3:0] OpSlt = 4'b0100;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_over_q, rsp_over_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant0, grant1;
    logic             accept0, accept1;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_data;
    logic             alu_over, alu_err;

    // On contention the requester that was not granted last time wins.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_q);
        grant1     = req1_valid && (!req0_valid || !last_q);
        req0_ready = rst_n && (state_q == StIdle) && grant0;
        req1_ready = rst_n && (state_q == StIdle) && grant1;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
    end

    always_comb begin
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        alu_data = '0;
        alu_over = 1'b0;
        alu_err  = 1'b0;
        case (op_q)
            OpAdd: begin
                alu_data = sum;
                alu_over = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpSub: begin
                alu_data = diff;
                alu_over = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpOr:    alu_data = a_q | b_q;
            OpAnd:   alu_data = a_q & b_q;
            OpSlt:   alu_data = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_over_d = rsp_over_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept0 || accept1) begin
                    state_d = StExec;
                    last_d  = accept1;
                    id_d    = accept1;
                    op_d    = accept1 ? req1_op : req0_op;
                    a_d     = accept1 ? req1_a  : req0_a;
                    b_d     = accept1 ? req1_b  : req0_b;
                end
            end
            StExec: begin
                state_d    = StResp;
                rsp_id_d   = id_q;
                rsp_data_d = alu_data;
                rsp_over_d = alu_over;
                rsp_err_d  = alu_err;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_over_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_over_q <= rsp_over_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == StResp);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_over  = rsp_over_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: vector table plus contention, backpressure and
// reset-abort sequences, all responses checked through an expected-result queue.
module tb_alu_arb;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        over;
        logic        err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        over;
        logic        err;
        int          acc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_over, rsp_err;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hs = 0;
    logic prev_valid = 1'b0;
    vec_t exp0, exp1;
    vec_t vecs[14];
    sb_t  sb[$];
    int   glog[$];

    alu_arb #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_over   (rsp_over),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept and response monitor, sampled 2 time units after the falling edge.
    always @(negedge clk) begin : mon
        sb_t e;
        #2;
        if (rst_n) begin
            if (req0_valid && req0_ready) begin
                e = '{id: 1'b0, data: exp0.data, over: exp0.over, err: exp0.err, acc: cyc};
                sb.push_back(e);
                glog.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                e = '{id: 1'b1, data: exp1.data, over: exp1.over, err: exp1.err, acc: cyc};
                sb.push_back(e);
                glog.push_back(1);
            end
            if (rsp_valid && !prev_valid && sb.size() > 0)
                check("latency", 32'(cyc - sb[0].acc), 32'd2);
            if (rsp_valid && rsp_ready) begin
                hs++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_over", {31'd0, rsp_over}, {31'd0, e.over});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic issue(input bit port, input vec_t v);
        bit done;
        done = 1'b0;
        @(negedge clk);
        if (port) begin
            exp1 = v; req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
        end else begin
            exp0 = v; req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            #2;
            if (port ? req1_ready : req0_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (port) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0 && !rsp_valid) done = 1'b1;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int h0;
        vecs[0]  = '{4'h0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1]  = '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
        vecs[2]  = '{4'h1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        vecs[4]  = '{4'h4, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5]  = '{4'h7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[6]  = '{4'h2, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[7]  = '{4'h3, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1'b0, 1'b0};
        vecs[8]  = '{4'h1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vecs[9]  = '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
        vecs[10] = '{4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[11] = '{4'h0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[12] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1};
        vecs[13] = '{4'h4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};

        // Reset with both requesters already asking (contention from reset).
        rst_n = 1'b0; rsp_ready = 1'b1;
        exp0 = '{4'h2, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0};
        exp1 = '{4'h3, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0};
        req0_op = 4'h2; req0_a = 32'hF0; req0_b = 32'h0F; req0_valid = 1'b1;
        req1_op = 4'h3; req1_a = 32'hFF; req1_b = 32'h0F; req1_valid = 1'b1;
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_rsp_over", {31'd0, rsp_over}, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #3;
            if (glog.size() >= 4) seen = 1'b1;
        end
        check("contention_grants", 32'(glog.size()), 32'd4);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_order_%0d", i), 32'(glog.size() > i ? glog[i] : 9), 32'(i % 2));

        // Vector table, alternating requester ports.
        for (int i = 0; i < 14; i++) begin
            issue(bit'(i % 2), vecs[i]);
            wait_drain();
        end

        // Backpressure: hold rsp_ready low for 5 RESP cycles while req1 waits.
        rsp_ready = 1'b0;
        issue(1'b0, vecs[8]);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            #3;
            if (rsp_valid) seen = 1'b1;
        end
        check("bp_rsp_seen", {31'd0, seen}, 32'd1);
        exp1 = vecs[7];
        req1_op = vecs[7].op; req1_a = vecs[7].a; req1_b = vecs[7].b; req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #3;
            end
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data", rsp_data, 32'h2);
            check("bp_id", {30'd0, rsp_err, rsp_id}, 32'd0);
            check("bp_over", {31'd0, rsp_over}, 32'd0);
            check("bp_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        h0 = hs;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #3;
        check("bp_one_handshake", 32'(hs - h0), 32'd1);
        check("bp_idle_after", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_drain();

        // Reset during EXEC: transaction dropped, held req1 re-arbitrated first.
        issue(1'b0, vecs[0]);
        exp1 = vecs[7];
        req1_op = vecs[7].op; req1_a = vecs[7].a; req1_b = vecs[7].b; req1_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_flags", {29'd0, rsp_id, rsp_over, rsp_err}, 32'd0);
        check("rst_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        glog.delete();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #3;
            if (glog.size() > 0) seen = 1'b1;
            @(negedge clk);
        end
        req1_valid = 1'b0;
        check("rst_first_grant", 32'(glog.size() > 0 ? glog[0] : 9), 32'd1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
